fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC value loaded on reset; SHALL be word-aligned.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: stall  input  1  hold PC and IF/ID contents.
REQ-005 Port: flush  input  1  squash IF/ID contents (insert bubble).
REQ-006 Port: halt_req  input  1  request entry to HALTED state.
REQ-007 Port: redirect_valid  input  1  branch/jump taken this cycle.
REQ-008 Port: redirect_pc  input  32  branch/jump target.
REQ-009 Port: imem_addr  output  32  fetch address to instruction memory; combinationally equals the PC register.
REQ-010 Port: imem_rdata  input  32  instruction returned combinationally by instruction memory for imem_addr.
REQ-011 Port: if_id_valid  output  1  IF/ID register holds a real instruction.
REQ-012 Port: if_id_instr  output  32  registered instruction.
REQ-013 Port: if_id_pc  output  32  address of registered instruction.
REQ-014 Port: if_id_pc_plus4  output  32  if_id_pc + 4, modulo 2^32.
REQ-015 Port: halted  output  1  high while FSM is in HALTED.
REQ-016 Port: misalign_err  output  1  sticky flag: a redirect with redirect_pc[1:0] != 0 occurred.
REQ-017 Port: fetch_count  output  32  number of valid instructions captured into IF/ID.

Function
REQ-018 FSM states: RUN, HALTED; every action below is evaluated per rising edge with rst_n high.
REQ-019 Priority per cycle: redirect_valid > halt_req > flush > stall > normal advance.
REQ-020 RUN, normal (no other input high): PC <= PC+4; IF/ID <= {valid=1, instr=imem_rdata, pc=PC, pc_plus4=PC+4}; fetch_count increments.
REQ-021 PC+4 arithmetic SHALL wrap: 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-022 RUN, stall only: PC and all IF/ID fields hold; fetch_count holds.
REQ-023 RUN, flush (stall either value): IF/ID valid <= 0, if_id_instr <= 32'h0; PC advances by 4 if stall low, holds if stall high.
REQ-024 redirect_valid (any state, overrides stall/flush/halt_req): PC <= {redirect_pc[31:2], 2'b00}; IF/ID valid <= 0, instr <= 0; state <= RUN.
REQ-025 redirect_valid with redirect_pc[1:0] != 0: misalign_err <= 1, held until reset; low bits forced to zero per REQ-024.
REQ-026 RUN, halt_req without redirect: state <= HALTED; PC holds; IF/ID valid <= 0, instr <= 0.
REQ-027 HALTED: PC and IF/ID hold; stall, flush, halt_req ignored; exit only via redirect_valid (REQ-024) or reset.
REQ-028 fetch_count increments only when if_id_valid is written 1; saturates at 32'hFFFF_FFFF.
REQ-029 When if_id_valid=0, if_id_pc and if_id_pc_plus4 hold their previous values.
REQ-030 imem_addr SHALL have zero cycles latency from the PC register; IF/ID outputs update one cycle after imem_addr presents the address.

Reset
REQ-031 While rst_n sampled low: PC <= RESET_PC, state <= RUN, if_id_valid <= 0, if_id_instr/if_id_pc/if_id_pc_plus4 <= 0, halted <= 0, misalign_err <= 0, fetch_count <= 0.
REQ-032 Reset SHALL override all other inputs, including mid-halt and mid-stall; first fetch after release uses RESET_PC.

Verification
REQ-033 Reset release, imem returns addr-tagged words, 3 free cycles -> if_id_pc 0,4,8; valid=1; fetch_count=3; imem_addr=0xC.
REQ-034 PC=0x10, stall high 2 cycles then low -> IF/ID and PC frozen 2 cycles, then if_id_pc=0x10, PC=0x14.
REQ-035 PC=0x20, redirect_valid with redirect_pc=0x102 and stall=1 -> next cycle PC=0x100, if_id_valid=0, misalign_err=1; following cycle if_id_pc=0x100.
REQ-036 halt_req at PC=0x40 -> halted=1, PC stays 0x40 for 5 cycles despite flush/stall toggling; redirect to 0x80 -> halted=0, PC=0x80.
REQ-037 Redirect to 0xFFFF_FFFC, one free cycle -> if_id_pc=0xFFFF_FFFC, if_id_pc_plus4=0, PC=0.
REQ-038 rst_n low for one cycle while halted with misalign_err=1 -> all outputs at REQ-031 values, PC=RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register, RUN/HALTED
// control, sticky misaligned-redirect flag and saturating fetch counter.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        halt_req,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic        halted,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    localparam int unsigned XLEN = 32;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_e;

    state_e            state_q;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   pc_plus4;
    logic [XLEN-1:0]   redirect_aligned;
    logic [XLEN-1:0]   fetch_count_inc;
    logic              if_id_valid_q;
    logic [XLEN-1:0]   if_id_instr_q;
    logic [XLEN-1:0]   if_id_pc_q;
    logic [XLEN-1:0]   if_id_pc_plus4_q;
    logic              halted_q;
    logic              misalign_err_q;
    logic [XLEN-1:0]   fetch_count_q;

    // Sequential-address arithmetic; the 32-bit add wraps naturally.
    assign pc_plus4         = pc_q + XLEN'(4);
    assign redirect_aligned = {redirect_pc[XLEN-1:2], 2'b00};
    assign fetch_count_inc  = (fetch_count_q == {XLEN{1'b1}}) ? fetch_count_q
                                                              : fetch_count_q + XLEN'(1);

    // Fetch address is the PC register itself, no extra latency.
    assign imem_addr = pc_q;

    // FSM plus all datapath registers; redirect beats halt beats flush beats stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= ST_RUN;
            pc_q             <= RESET_PC;
            if_id_valid_q    <= 1'b0;
            if_id_instr_q    <= '0;
            if_id_pc_q       <= '0;
            if_id_pc_plus4_q <= '0;
            halted_q         <= 1'b0;
            misalign_err_q   <= 1'b0;
            fetch_count_q    <= '0;
        end else if (redirect_valid) begin
            state_q       <= ST_RUN;
            halted_q      <= 1'b0;
            pc_q          <= redirect_aligned;
            if_id_valid_q <= 1'b0;
            if_id_instr_q <= '0;
            if (redirect_pc[1:0] != 2'b00) begin
                misalign_err_q <= 1'b1;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (halt_req) begin
                        state_q       <= ST_HALTED;
                        halted_q      <= 1'b1;
                        if_id_valid_q <= 1'b0;
                        if_id_instr_q <= '0;
                    end else if (flush) begin
                        if_id_valid_q <= 1'b0;
                        if_id_instr_q <= '0;
                        if (!stall) begin
                            pc_q <= pc_plus4;
                        end
                    end else if (!stall) begin
                        pc_q             <= pc_plus4;
                        if_id_valid_q    <= 1'b1;
                        if_id_instr_q    <= imem_rdata;
                        if_id_pc_q       <= pc_q;
                        if_id_pc_plus4_q <= pc_plus4;
                        fetch_count_q    <= fetch_count_inc;
                    end
                end
                ST_HALTED: begin
                    // Only a redirect or reset leaves HALTED; everything holds.
                    state_q <= ST_HALTED;
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    assign if_id_valid    = if_id_valid_q;
    assign if_id_instr    = if_id_instr_q;
    assign if_id_pc       = if_id_pc_q;
    assign if_id_pc_plus4 = if_id_pc_plus4_q;
    assign halted         = halted_q;
    assign misalign_err   = misalign_err_q;
    assign fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed cycles, captured instructions checked by a
// queue-based monitor, control/status outputs checked directly.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, halt_req, redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr, imem_rdata;
    logic        if_id_valid;
    logic [31:0] if_id_instr, if_id_pc, if_id_pc_plus4;
    logic        halted, misalign_err;
    logic [31:0] fetch_count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    exp_t exp_q[$];

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .flush          (flush),
        .halt_req       (halt_req),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .halted         (halted),
        .misalign_err   (misalign_err),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    // Instruction memory returns an address-tagged word.
    function automatic logic [31:0] tag(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction
    assign imem_rdata = tag(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Expected capture for a free-running cycle fetching from address a.
    task automatic expect_fetch(input logic [31:0] a, input logic [31:0] a4);
        exp_t e;
        e.pc    = a;
        e.instr = tag(a);
        e.pc4   = a4;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input logic s, input logic f, input logic h,
                       input logic rv, input logic [31:0] rp);
        stall          = s;
        flush          = f;
        halt_req       = h;
        redirect_valid = rv;
        redirect_pc    = rp;
        @(posedge clk);
        #1;
    endtask

    // Monitor: each new valid capture (counter moved) pops one expectation.
    logic [31:0] prev_fc = 32'h0;
    always @(negedge clk) begin
        if (rst_n === 1'b1 && if_id_valid === 1'b1 && fetch_count !== prev_fc) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_capture", if_id_pc, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("cap_pc", if_id_pc, e.pc);
                chk("cap_instr", if_id_instr, e.instr);
                chk("cap_pc4", if_id_pc_plus4, e.pc4);
            end
        end
        prev_fc = fetch_count;
    end

    initial begin
        rst_n = 1'b0;
        cyc(0, 0, 0, 0, 32'h0);
        cyc(0, 0, 0, 0, 32'h0);
        chk("rst_valid", 32'(if_id_valid), 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_count", fetch_count, 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);

        // Three free cycles from reset.
        rst_n = 1'b1;
        expect_fetch(32'h0, 32'h4);  cyc(0, 0, 0, 0, 32'h0);
        expect_fetch(32'h4, 32'h8);  cyc(0, 0, 0, 0, 32'h0);
        expect_fetch(32'h8, 32'hC);  cyc(0, 0, 0, 0, 32'h0);
        chk("free_addr", imem_addr, 32'hC);
        chk("free_count", fetch_count, 32'd3);
        chk("free_valid", 32'(if_id_valid), 32'h1);
        expect_fetch(32'hC, 32'h10); cyc(0, 0, 0, 0, 32'h0);

        // Stall two cycles at PC=0x10.
        cyc(1, 0, 0, 0, 32'h0);
        chk("stall1_addr", imem_addr, 32'h10);
        chk("stall1_pc", if_id_pc, 32'hC);
        cyc(1, 0, 0, 0, 32'h0);
        chk("stall2_addr", imem_addr, 32'h10);
        chk("stall2_count", fetch_count, 32'd4);
        expect_fetch(32'h10, 32'h14); cyc(0, 0, 0, 0, 32'h0);
        chk("unstall_addr", imem_addr, 32'h14);
        chk("unstall_pc", if_id_pc, 32'h10);
        expect_fetch(32'h14, 32'h18); cyc(0, 0, 0, 0, 32'h0);
        expect_fetch(32'h18, 32'h1C); cyc(0, 0, 0, 0, 32'h0);
        expect_fetch(32'h1C, 32'h20); cyc(0, 0, 0, 0, 32'h0);
        chk("pre_redir_addr", imem_addr, 32'h20);

        // Misaligned redirect overriding stall.
        cyc(1, 0, 0, 1, 32'h102);
        chk("redir_addr", imem_addr, 32'h100);
        chk("redir_valid", 32'(if_id_valid), 32'h0);
        chk("redir_instr", if_id_instr, 32'h0);
        chk("redir_mis", 32'(misalign_err), 32'h1);
        expect_fetch(32'h100, 32'h104); cyc(0, 0, 0, 0, 32'h0);
        chk("post_redir_pc", if_id_pc, 32'h100);
        chk("post_redir_count", fetch_count, 32'd9);

        // Flush with and without stall.
        cyc(0, 1, 0, 0, 32'h0);
        chk("flush_valid", 32'(if_id_valid), 32'h0);
        chk("flush_addr", imem_addr, 32'h108);
        chk("flush_hold_pc", if_id_pc, 32'h100);
        cyc(1, 1, 0, 0, 32'h0);
        chk("flushstall_addr", imem_addr, 32'h108);
        chk("flush_count", fetch_count, 32'd9);

        // Halt at 0x40, ignore flush/stall/halt, redirect out.
        cyc(0, 0, 0, 1, 32'h40);
        chk("redir40_mis_sticky", 32'(misalign_err), 32'h1);
        cyc(0, 0, 1, 0, 32'h0);
        chk("halt_on", 32'(halted), 32'h1);
        chk("halt_addr", imem_addr, 32'h40);
        for (int i = 0; i < 5; i++) begin
            cyc(1'(i), 1'(i + 1), 1'(i >> 1), 0, 32'h0);
            chk("halted_addr", imem_addr, 32'h40);
            chk("halted_flag", 32'(halted), 32'h1);
        end
        chk("halted_count", fetch_count, 32'd9);
        cyc(1, 1, 1, 1, 32'h80);
        chk("unhalt_flag", 32'(halted), 32'h0);
        chk("unhalt_addr", imem_addr, 32'h80);

        // Wrap at top of address space.
        cyc(0, 0, 0, 1, 32'hFFFF_FFFC);
        expect_fetch(32'hFFFF_FFFC, 32'h0); cyc(0, 0, 0, 0, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_pc4", if_id_pc_plus4, 32'h0);
        chk("wrap_count", fetch_count, 32'd10);

        // Reset while halted with error flag set.
        cyc(0, 0, 1, 0, 32'h0);
        chk("halt2_on", 32'(halted), 32'h1);
        rst_n = 1'b0;
        cyc(1, 1, 1, 0, 32'h0);
        chk("rst2_halted", 32'(halted), 32'h0);
        chk("rst2_mis", 32'(misalign_err), 32'h0);
        chk("rst2_addr", imem_addr, 32'h0);
        chk("rst2_valid", 32'(if_id_valid), 32'h0);
        chk("rst2_pc", if_id_pc, 32'h0);
        chk("rst2_pc4", if_id_pc_plus4, 32'h0);
        chk("rst2_count", fetch_count, 32'h0);
        rst_n = 1'b1;
        expect_fetch(32'h0, 32'h4); cyc(0, 0, 0, 0, 32'h0);
        chk("rst2_first_count", fetch_count, 32'd1);

        cyc(1, 0, 0, 0, 32'h0);
        cyc(1, 0, 0, 0, 32'h0);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
